mdu: RTL and testbench

Multiply/divide unit sitting directly downstream of the register file: it consumes the two register read ports (RD1, RD2) as operands, performs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and holds the results in architectural HI/LO registers. It also handles MTHI/MTLO. HI/LO are exposed for MFHI/MFLO. A `busy` flag tells the pipeline to stall any HI/LO consumer until the operation commits.

---
 rtl/mdu.sv | 75 +++++++
 tb/tb_mdu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO registers.
// A result is computed when the operation starts and is committed to HI/LO after a fixed latency.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, ld;
  logic [31:0] p_hi, p_lo;
  logic        p_ok;
  logic        go, done, b_nz, ok;
  logic [63:0] mul_s, mul_u, res;
  logic [31:0] a_mag, b_mag, q_m, r_m, q_s, r_s, q_u, r_u;
  always_comb begin
    go = state == IDLE && start && !op[2];
    done = state == RUN && cnt == CW'(1);
    state_nx = go ? RUN : (done ? IDLE : state);
    mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    mul_u = {32'b0, A} * {32'b0, B};
    b_nz = B != 32'b0;
    // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    a_mag = A[31] ? -A : A;
    b_mag = B[31] ? -B : B;
    q_m = b_nz ? a_mag / b_mag : '0;
    r_m = b_nz ? a_mag % b_mag : '0;
    q_s = (A[31] ^ B[31]) ? -q_m : q_m;
    r_s = A[31] ? -r_m : r_m;
    q_u = b_nz ? A / B : '0;
    r_u = b_nz ? A % B : '0;
    res = op[1] ? (op[0] ? {r_u, q_u} : {r_s, q_s}) : (op[0] ? mul_u : mul_s);
    ok = !op[1] || b_nz;
    ld = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      HI   <= '0;
      LO   <= '0;
      p_hi <= '0;
      p_lo <= '0;
      p_ok <= 1'b0;
    end else if (state == IDLE) begin
      if (go) begin
        cnt          <= ld;
        {p_hi, p_lo} <= res;
        p_ok         <= ok;
      end
      if (start && op == 3'd4) HI <= A;
      if (start && op == 3'd5) LO <= A;
    end else begin
      cnt <= cnt - CW'(1);
      if (done && p_ok) begin
        HI <= p_hi;
        LO <= p_lo;
      end
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against an arithmetic HI/LO reference model.
module tb_mdu;
  logic        clk = 0, reset = 1, start = 0;
  logic [2:0]  op = 0;
  logic [31:0] A = 0, B = 0;
  logic        busy;
  logic [31:0] HI, LO;
  int asserts = 0, fails = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
           .busy(busy), .HI(HI), .LO(LO));

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, hi, lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] o);
    return o < 2 ? 5 : (o < 4 ? 10 : 0);
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                        input bit scramble, input bit b2b, output int bcnt);
    if (!b2b) @(negedge clk);
    start = 1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 0;
    {m_hi, m_lo} = model(o, a, b, m_hi, m_lo);
    bcnt = 0;
    while (busy === 1'b1 && bcnt < 50) begin
      if (scramble) begin A = $urandom; B = $urandom; end
      @(posedge clk); #1;
      bcnt++;
    end
  endtask

  task automatic test_reset;
    int n;
    #2 reset = 0;
    #1;
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    asserts++; if ({HI, LO} !== 64'h0) begin fails++; $display("FAIL reset_hilo got %h_%h want 0", HI, LO); end
    @(negedge clk); reset = 1;
    run_op(3'd4, 32'hAAAA5555, 0, 0, 0, n);
    run_op(3'd5, 32'h12345678, 0, 0, 0, n);
    @(negedge clk); start = 1; op = 3'd2; A = 100; B = 7;
    @(posedge clk); #1; start = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    #1;
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b want 0", busy); end
    asserts++; if ({HI, LO} !== 64'h0) begin fails++; $display("FAIL abort_hilo got %h_%h want 0", HI, LO); end
    m_hi = 0; m_lo = 0;
    @(negedge clk); reset = 1;
    run_op(3'd1, 3, 5, 0, 1, n);
    asserts++; if (n != 5) begin fails++; $display("FAIL post_reset_busy got %0d want 5", n); end
    asserts++; if (HI !== 32'h0 || LO !== 32'hF) begin fails++; $display("FAIL post_reset_multu got %h_%h want 0_f", HI, LO); end
  endtask

  task automatic test_mult;
    int n;
    run_op(3'd0, 32'hFFFFFFFE, 3, 0, 0, n);
    asserts++; if (n != 5) begin fails++; $display("FAIL mult_busy got %0d want 5", n); end
    asserts++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult got %h_%h want ffffffff_fffffffa", HI, LO); end
    run_op(3'd1, 32'hFFFFFFFE, 3, 0, 0, n);
    asserts++; if (HI !== 32'h2 || LO !== 32'hFFFFFFFA) begin fails++; $display("FAIL multu got %h_%h want 00000002_fffffffa", HI, LO); end
  endtask

  task automatic test_div;
    int n;
    run_op(3'd2, 32'hFFFFFFF9, 2, 0, 0, n);
    asserts++; if (n != 10) begin fails++; $display("FAIL div_busy got %0d want 10", n); end
    asserts++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin fails++; $display("FAIL div got %h_%h want ffffffff_fffffffd", HI, LO); end
    run_op(3'd3, 7, 2, 0, 0, n);
    asserts++; if (HI !== 32'h1 || LO !== 32'h3) begin fails++; $display("FAIL divu got %h_%h want 1_3", HI, LO); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, n);
    asserts++; if (HI !== 32'h0 || LO !== 32'h80000000) begin fails++; $display("FAIL div_ovf got %h_%h want 0_80000000", HI, LO); end
  endtask

  task automatic test_div_zero;
    int n;
    run_op(3'd4, 32'h11111111, 0, 0, 0, n);
    asserts++; if (n != 0 || HI !== 32'h11111111) begin fails++; $display("FAIL mthi got busy %0d hi %h want 0 11111111", n, HI); end
    run_op(3'd5, 32'h22222222, 0, 0, 0, n);
    asserts++; if (n != 0 || LO !== 32'h22222222) begin fails++; $display("FAIL mtlo got busy %0d lo %h want 0 22222222", n, LO); end
    run_op(3'd2, 32'h55, 0, 0, 0, n);
    asserts++; if (n != 10) begin fails++; $display("FAIL div0_busy got %0d want 10", n); end
    asserts++; if (HI !== 32'h11111111 || LO !== 32'h22222222) begin fails++; $display("FAIL div0 got %h_%h want 11111111_22222222", HI, LO); end
  endtask

  task automatic test_start_busy;
    int n;
    @(negedge clk); start = 1; op = 3'd0; A = 7; B = 6;
    @(posedge clk); #1;
    op = 3'd4; A = 32'hDEADBEEF;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      start = 0;
      n++;
    end
    start = 0;
    m_hi = 0; m_lo = 42;
    asserts++; if (n != 5) begin fails++; $display("FAIL busy_ignore_len got %0d want 5", n); end
    asserts++; if (HI !== 32'h0 || LO !== 32'd42) begin fails++; $display("FAIL busy_ignore got %h_%h want 0_2a", HI, LO); end
  endtask

  task automatic test_back_to_back;
    int n;
    run_op(3'd0, 32'd1234, 32'd5678, 1, 0, n);
    asserts++; if (HI !== m_hi || LO !== m_lo) begin fails++; $display("FAIL hold got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
    run_op(3'd0, 32'hFFFFFFFD, 32'd100000, 1, 1, n);
    asserts++; if (n != 5) begin fails++; $display("FAIL b2b_busy got %0d want 5", n); end
    asserts++; if (HI !== m_hi || LO !== m_lo) begin fails++; $display("FAIL b2b got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_random;
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom_range(0, 4) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(o, a, b, 1, 1'($urandom_range(0, 1)), n);
      asserts++; if (n != exp_busy(o)) begin fails++; $display("FAIL rnd_busy[%0d] op %0d got %0d want %0d", i, o, n, exp_busy(o)); end
      asserts++; if (HI !== m_hi || LO !== m_lo) begin fails++; $display("FAIL rnd[%0d] op %0d a %h b %h got %h_%h want %h_%h", i, o, a, b, HI, LO, m_hi, m_lo); end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_start_busy;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
